// File: rtl/cron_ctrl.sv
// cron_ctrl: stopwatch control -- debounced start/stop and lap/reset buttons
// drive a 4-state FSM that gates the counter, freezes lap values and tracks overflow.
module cron_ctrl #(
    parameter int DEB_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_ss,
    input  logic       btn_lr,
    input  logic [9:0] q,
    input  logic       tick_1s,
    output logic       run,
    output logic       cnt_clr,
    output logic [9:0] disp,
    output logic       lap_active,
    output logic       ovf,
    output logic [1:0] state
);
    localparam int CW = $clog2(DEB_CYCLES + 1);

    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, LAP = 2'b11} state_t;

    logic [1:0]    sync1_q, sync2_q, lvl_q, lvl_prev_q, ev;
    logic [CW-1:0] cnt_q [2];
    state_t        state_q, state_d;
    logic [9:0]    lap_q, lap_d;
    logic          clr_q, clr_d, ovf_q;
    logic          ss_ev, lr_ev;

    // bit 0 = start/stop, bit 1 = lap/reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            lvl_q      <= '0;
            lvl_prev_q <= '0;
            for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q    <= {btn_lr, btn_ss};
            sync2_q    <= sync1_q;
            lvl_prev_q <= lvl_q;
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == lvl_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CW'(DEB_CYCLES - 1)) begin
                    cnt_q[i] <= '0;
                    lvl_q[i] <= ~lvl_q[i];
                end else begin
                    cnt_q[i] <= cnt_q[i] + CW'(1);
                end
            end
        end
    end

    assign ev    = lvl_q & ~lvl_prev_q;
    assign ss_ev = ev[0];
    assign lr_ev = ev[1];

    // start/stop wins over a same-cycle lap/reset press
    always_comb begin
        state_d = state_q;
        lap_d   = lap_q;
        clr_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (ss_ev)      state_d = RUN;
                else if (lr_ev) clr_d = 1'b1;
            end
            RUN: begin
                if (ss_ev) begin
                    state_d = PAUSE;
                end else if (lr_ev) begin
                    lap_d   = q;
                    state_d = LAP;
                end
            end
            LAP: begin
                if (ss_ev)      state_d = PAUSE;
                else if (lr_ev) lap_d = q;
            end
            default: begin
                if (ss_ev) begin
                    state_d = RUN;
                end else if (lr_ev) begin
                    clr_d   = 1'b1;
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lap_q   <= '0;
            clr_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lap_q   <= lap_d;
            clr_q   <= clr_d;
            if (clr_d)                            ovf_q <= 1'b0;
            else if (run && tick_1s && q == 10'd999) ovf_q <= 1'b1;
        end
    end

    assign run        = (state_q == RUN) || (state_q == LAP);
    assign lap_active = (state_q == LAP);
    assign disp       = lap_active ? lap_q : q;
    assign cnt_clr    = clr_q;
    assign ovf        = ovf_q;
    assign state      = state_q;
endmodule

// File: tb/tb_cron_ctrl.sv
// tb_cron_ctrl: scoreboard bench for cron_ctrl with DEB_CYCLES=4; stimulus queues
// expected state transitions, snapshots and clear pulses, a negedge monitor checks them.
module tb_cron_ctrl;
    logic       clk = 1'b0;
    logic       rst_n, btn_ss, btn_lr, tick_1s;
    logic [9:0] q;
    logic       run, cnt_clr, lap_active, ovf;
    logic [9:0] disp;
    logic [1:0] state;

    typedef struct {
        string      name;
        logic [1:0] st;
        logic       run;
        logic [9:0] disp;
        logic       lap;
        logic       ovf;
    } exp_t;

    exp_t  sq[$];
    exp_t  nq[$];
    string cq[$];
    int    checks = 0;
    int    errors = 0;
    logic [1:0] prev_st = 2'b00;
    logic       prev_clr = 1'b0;

    cron_ctrl #(.DEB_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .btn_ss(btn_ss), .btn_lr(btn_lr), .q(q),
        .tick_1s(tick_1s), .run(run), .cnt_clr(cnt_clr), .disp(disp),
        .lap_active(lap_active), .ovf(ovf), .state(state)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input string n, input logic [1:0] s, input logic r,
                                input logic [9:0] d, input logic l, input logic o);
        exp_t e;
        e.name = n; e.st = s; e.run = r; e.disp = d; e.lap = l; e.ovf = o;
        return e;
    endfunction

    task automatic cmp(input exp_t e);
        checks++;
        if (state !== e.st || run !== e.run || disp !== e.disp || lap_active !== e.lap || ovf !== e.ovf) begin
            errors++;
            $display("FAIL %s: got state=%0d run=%0b disp=%0d lap=%0b ovf=%0b, want state=%0d run=%0b disp=%0d lap=%0b ovf=%0b",
                     e.name, state, run, disp, lap_active, ovf, e.st, e.run, e.disp, e.lap, e.ovf);
        end
    endtask

    always @(negedge clk) begin
        if (state !== prev_st) begin
            if (sq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_state_change: got state=%0d from %0d, want no change", state, prev_st);
            end else begin
                cmp(sq.pop_front());
            end
        end
        prev_st = state;
        if (nq.size() > 0) cmp(nq.pop_front());
        if (cnt_clr === 1'b1) begin
            checks++;
            if (prev_clr) begin
                errors++;
                $display("FAIL cnt_clr_width: got cnt_clr high 2+ cycles, want 1");
            end else if (cq.size() == 0) begin
                errors++;
                $display("FAIL cnt_clr_unexpected: got cnt_clr=1 in state=%0d, want 0", state);
            end else begin
                void'(cq.pop_front());
            end
        end
        prev_clr = cnt_clr;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic ss, input logic lr);
        btn_ss = ss;
        btn_lr = lr;
        cyc(10);
        btn_ss = 1'b0;
        btn_lr = 1'b0;
        cyc(12);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        rst_n = 1'b0; btn_ss = 1'b0; btn_lr = 1'b0; tick_1s = 1'b0; q = 10'd5;
        nq.push_back(mk("reset_state", 2'b00, 0, 10'd5, 0, 0));
        cyc(2);
        rst_n = 1'b1;
        q = 10'd10;
        cyc(2);
        // clean start press, run must rise within 8 cycles
        sq.push_back(mk("idle_to_run", 2'b01, 1, 10'd10, 0, 0));
        btn_ss = 1'b1;
        n = 0;
        while (run !== 1'b1 && n < 8) begin
            cyc(1);
            n++;
        end
        checks++;
        if (run !== 1'b1) begin
            errors++;
            $display("FAIL run_latency: got run=%0b after %0d cycles, want 1 within 8", run, n);
        end
        cyc(3);
        btn_ss = 1'b0;
        cyc(12);
        sq.push_back(mk("run_to_pause", 2'b10, 0, 10'd10, 0, 0));
        press(1, 0);
        sq.push_back(mk("pause_lr_to_idle", 2'b00, 0, 10'd10, 0, 0));
        cq.push_back("pause_clr");
        press(0, 1);
        cq.push_back("idle_clr");
        press(0, 1);
        // bouncy start press
        q = 10'd123;
        sq.push_back(mk("bouncy_to_run", 2'b01, 1, 10'd123, 0, 0));
        for (int i = 0; i < 2; i++) begin
            btn_ss = 1'b1; cyc(3);
            btn_ss = 1'b0; cyc(1);
        end
        btn_ss = 1'b1; cyc(10);
        btn_ss = 1'b0; cyc(12);
        sq.push_back(mk("run_to_lap", 2'b11, 1, 10'd123, 1, 0));
        press(0, 1);
        q = 10'd125;
        nq.push_back(mk("lap_frozen", 2'b11, 1, 10'd123, 1, 0));
        cyc(1);
        q = 10'd130;
        press(0, 1);
        nq.push_back(mk("lap_split", 2'b11, 1, 10'd130, 1, 0));
        cyc(1);
        q = 10'd140;
        nq.push_back(mk("lap_split_frozen", 2'b11, 1, 10'd130, 1, 0));
        cyc(1);
        sq.push_back(mk("lap_to_pause", 2'b10, 0, 10'd140, 0, 0));
        press(1, 0);
        sq.push_back(mk("pause_to_run", 2'b01, 1, 10'd140, 0, 0));
        press(1, 0);
        // overflow
        q = 10'd999;
        cyc(1);
        tick_1s = 1'b1;
        nq.push_back(mk("ovf_before", 2'b01, 1, 10'd999, 0, 0));
        cyc(1);
        tick_1s = 1'b0;
        nq.push_back(mk("ovf_set", 2'b01, 1, 10'd999, 0, 1));
        cyc(1);
        q = 10'd0;
        tick_1s = 1'b1;
        cyc(1);
        tick_1s = 1'b0;
        nq.push_back(mk("ovf_sticky", 2'b01, 1, 10'd0, 0, 1));
        cyc(1);
        sq.push_back(mk("run_lr_no_clr", 2'b11, 1, 10'd0, 1, 1));
        press(0, 1);
        sq.push_back(mk("lap_to_pause2", 2'b10, 0, 10'd0, 0, 1));
        press(1, 0);
        q = 10'd50;
        sq.push_back(mk("pause_to_run2", 2'b01, 1, 10'd50, 0, 1));
        press(1, 0);
        sq.push_back(mk("both_to_pause", 2'b10, 0, 10'd50, 0, 1));
        press(1, 1);
        sq.push_back(mk("pause_clr_ovf", 2'b00, 0, 10'd50, 0, 0));
        cq.push_back("pause_clr2");
        press(0, 1);
        nq.push_back(mk("ovf_cleared", 2'b00, 0, 10'd50, 0, 0));
        cyc(1);
        // reset during LAP
        sq.push_back(mk("idle_to_run3", 2'b01, 1, 10'd50, 0, 0));
        press(1, 0);
        q = 10'd60;
        sq.push_back(mk("run_to_lap3", 2'b11, 1, 10'd60, 1, 0));
        press(0, 1);
        sq.push_back(mk("lap_reset", 2'b00, 0, 10'd60, 0, 0));
        nq.push_back(mk("lap_reset_snap", 2'b00, 0, 10'd60, 0, 0));
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        cyc(3);
        // button held through reset release
        rst_n = 1'b0;
        btn_ss = 1'b1;
        cyc(2);
        sq.push_back(mk("held_through_reset", 2'b01, 1, 10'd60, 0, 0));
        rst_n = 1'b1;
        cyc(12);
        btn_ss = 1'b0;
        cyc(12);
        cyc(5);
        checks++;
        if (sq.size() != 0) begin
            errors++;
            $display("FAIL state_queue_drain: got %0d pending, want 0", sq.size());
        end
        checks++;
        if (nq.size() != 0) begin
            errors++;
            $display("FAIL snap_queue_drain: got %0d pending, want 0", nq.size());
        end
        checks++;
        if (cq.size() != 0) begin
            errors++;
            $display("FAIL clr_queue_drain: got %0d missing cnt_clr pulses, want 0", cq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
